// File: rtl/f_ifu.sv
// Fetch stage and F/D pipeline register: PC register, fetch-address range check,
// fault masking of instruction data, and the Req/Stall/Eret-prioritised D-stage latch.
module f_ifu #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IM_TOP   = 32'h0000_6FFF,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] NPC,
    input  logic        Stall,
    input  logic        Req,
    input  logic        D_Eret,
    input  logic        D_IsBJ,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] i_inst_addr,
    output logic [31:0] F_PC,
    output logic [31:0] D_PC,
    output logic [31:0] D_Instr,
    output logic        D_BD,
    output logic [4:0]  D_ExcCode
);

    logic [31:0] pc_r;
    logic [31:0] d_pc_r;
    logic [31:0] d_instr_r;
    logic        d_bd_r;
    logic [4:0]  d_exc_r;

    logic        fault_s;
    logic [31:0] f_instr_s;
    logic [4:0]  f_code_s;

    function automatic logic addr_fault(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr < IM_BASE) || (addr > IM_TOP);
    endfunction

    // Fetch-side fault detection; a faulted fetch returns a null word and AdEL
    always_comb begin
        fault_s   = addr_fault(pc_r);
        f_instr_s = i_inst_rdata;
        f_code_s  = 5'd0;
        if (fault_s) begin
            f_instr_s = 32'h0000_0000;
            f_code_s  = 5'd4;
        end else begin
            f_instr_s = i_inst_rdata;
            f_code_s  = 5'd0;
        end
    end

    // PC register: NPC already carries hold/redirect targets, so it loads every edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= NPC;
        end
    end

    // F/D pipeline register with flush-over-stall-over-eret priority
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_pc_r    <= 32'h0000_0000;
            d_instr_r <= 32'h0000_0000;
            d_bd_r    <= 1'b0;
            d_exc_r   <= 5'd0;
        end else if (Req) begin
            d_pc_r    <= EXC_PC;
            d_instr_r <= 32'h0000_0000;
            d_bd_r    <= 1'b0;
            d_exc_r   <= 5'd0;
        end else if (Stall) begin
            d_pc_r    <= d_pc_r;
            d_instr_r <= d_instr_r;
            d_bd_r    <= d_bd_r;
            d_exc_r   <= d_exc_r;
        end else if (D_Eret) begin
            d_pc_r    <= pc_r;
            d_instr_r <= 32'h0000_0000;
            d_bd_r    <= 1'b0;
            d_exc_r   <= 5'd0;
        end else begin
            d_pc_r    <= pc_r;
            d_instr_r <= f_instr_s;
            d_bd_r    <= D_IsBJ;
            d_exc_r   <= f_code_s;
        end
    end

    assign i_inst_addr = pc_r;
    assign F_PC        = pc_r;
    assign D_PC        = d_pc_r;
    assign D_Instr     = d_instr_r;
    assign D_BD        = d_bd_r;
    assign D_ExcCode   = d_exc_r;

endmodule

// File: tb/tb_f_ifu.sv
// Scoreboard bench for f_ifu: a driver pushes expected post-edge state from a
// behavioural model, and an independent monitor pops and compares after each edge.
module tb_f_ifu;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] IM_BASE  = 32'h0000_3000;
    localparam logic [31:0] IM_TOP   = 32'h0000_6FFF;
    localparam logic [31:0] EXC_PC   = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] NPC;
    logic        Stall;
    logic        Req;
    logic        D_Eret;
    logic        D_IsBJ;
    logic [31:0] i_inst_rdata;
    logic [31:0] i_inst_addr;
    logic [31:0] F_PC;
    logic [31:0] D_PC;
    logic [31:0] D_Instr;
    logic        D_BD;
    logic [4:0]  D_ExcCode;

    f_ifu #(
        .RESET_PC(RESET_PC),
        .IM_BASE (IM_BASE),
        .IM_TOP  (IM_TOP),
        .EXC_PC  (EXC_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .NPC         (NPC),
        .Stall       (Stall),
        .Req         (Req),
        .D_Eret      (D_Eret),
        .D_IsBJ      (D_IsBJ),
        .i_inst_rdata(i_inst_rdata),
        .i_inst_addr (i_inst_addr),
        .F_PC        (F_PC),
        .D_PC        (D_PC),
        .D_Instr     (D_Instr),
        .D_BD        (D_BD),
        .D_ExcCode   (D_ExcCode)
    );

    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of the byte address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_3000) return 32'h2401_0001;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign i_inst_rdata = mem_word(i_inst_addr);

    typedef struct {
        int          cyc;
        logic [31:0] fpc;
        logic [31:0] dpc;
        logic [31:0] dinstr;
        logic        dbd;
        logic [4:0]  dcode;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;

    logic [31:0] m_pc, m_dpc, m_dinstr;
    logic        m_dbd;
    logic [4:0]  m_dcode;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_dpc = 0; m_dinstr = 0; m_dbd = 0; m_dcode = 0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_F_PC"}, F_PC, RESET_PC);
        chk({tag, "_addr"}, i_inst_addr, RESET_PC);
        chk({tag, "_D_PC"}, D_PC, 32'h0);
        chk({tag, "_D_Instr"}, D_Instr, 32'h0);
        chk({tag, "_D_BD"}, {31'h0, D_BD}, 32'h0);
        chk({tag, "_D_Exc"}, {27'h0, D_ExcCode}, 32'h0);
    endtask

    // Drive one cycle's inputs, advance the model by one edge, queue the expectation
    task automatic step(input logic [31:0] npc, input logic st, input logic rq,
                        input logic er, input logic bj);
        exp_t e;
        bit   bad;
        NPC = npc; Stall = st; Req = rq; D_Eret = er; D_IsBJ = bj;
        bad = ((m_pc % 4) != 0) || (m_pc < IM_BASE) || (m_pc > IM_TOP);
        if (rq) begin
            m_dpc = EXC_PC; m_dinstr = 0; m_dbd = 0; m_dcode = 0;
        end else if (st) begin
            // D holds
        end else if (er) begin
            m_dpc = m_pc; m_dinstr = 0; m_dbd = 0; m_dcode = 0;
        end else begin
            m_dpc    = m_pc;
            m_dinstr = bad ? 32'h0 : mem_word(m_pc);
            m_dbd    = bj;
            m_dcode  = bad ? 5'd4 : 5'd0;
        end
        m_pc = npc;
        e.cyc = edge_cnt + 1; e.fpc = m_pc; e.dpc = m_dpc; e.dinstr = m_dinstr;
        e.dbd = m_dbd; e.dcode = m_dcode;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every expectation due at this edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            while (q.size() > 0 && q[0].cyc <= edge_cnt) begin
                e = q.pop_front();
                chk("sb_edge", edge_cnt, e.cyc);
                chk("sb_F_PC", F_PC, e.fpc);
                chk("sb_addr", i_inst_addr, e.fpc);
                chk("sb_D_PC", D_PC, e.dpc);
                chk("sb_D_Instr", D_Instr, e.dinstr);
                chk("sb_D_BD", {31'h0, D_BD}, {31'h0, e.dbd});
                chk("sb_D_Exc", {27'h0, D_ExcCode}, {27'h0, e.dcode});
            end
        end
    end

    logic [31:0] bound_list [8] = '{32'h0000_2FFC, 32'h0000_3000, 32'h0000_6FFC, 32'h0000_7000,
                                    32'h0000_6FFF, 32'h0000_3001, 32'hFFFF_FFFC, 32'h0000_0000};

    initial begin
        logic [31:0] npc;
        int r;
        reset = 1'b1; NPC = 0; Stall = 0; Req = 0; D_Eret = 0; D_IsBJ = 0;
        #1;
        check_reset_state("rst_init");
        @(posedge clk);
        #3;
        reset = 1'b0;
        model_reset();

        // basic fetch, stall hold, boundary faults
        step(32'h0000_3004, 0, 0, 0, 0);
        step(m_pc, 1, 0, 0, 0);
        step(m_pc, 1, 0, 0, 0);
        step(32'h0000_3002, 0, 0, 0, 0);
        step(32'h0000_7000, 0, 0, 0, 0);
        step(32'h0000_6FFC, 0, 0, 0, 0);
        step(32'h0000_2FFC, 0, 0, 0, 0);
        step(32'h0000_3008, 0, 0, 0, 0);
        // flush beats stall
        step(EXC_PC, 1, 1, 0, 0);
        step(32'h0000_4184, 0, 0, 0, 1);
        step(32'h0000_4188, 0, 0, 0, 0);
        step(32'h0000_418C, 0, 0, 1, 0);
        step(32'h0000_4190, 1, 0, 1, 1);
        step(32'h0000_3010, 0, 0, 0, 0);

        // asynchronous reset mid-run, held across an edge with stall and flush asserted
        #3;
        reset = 1'b1;
        #1;
        check_reset_state("rst_async");
        Stall = 1'b1; Req = 1'b1; NPC = 32'h0000_5000;
        @(posedge clk);
        #1;
        check_reset_state("rst_held");
        #7;
        reset = 1'b0;
        model_reset();
        step(32'h0000_3004, 0, 0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3, 4: npc = m_pc + 32'd4;
                5:             npc = bound_list[$urandom_range(0, 7)];
                6:             npc = IM_BASE + 32'd4 * $urandom_range(0, (IM_TOP - IM_BASE) / 4);
                7:             npc = m_pc;
                8:             npc = $urandom;
                default:       npc = EXC_PC;
            endcase
            step(npc, ($urandom_range(0, 4) == 0), ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0));
        end

        @(posedge clk);
        #5;
        chk("sb_drained", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
